// File: rtl/load_data_unit_if.sv
// ============================================================================
// Module      : load_data_unit_if
// Description : Load request, data-memory read port and writeback signals
//               of the load data unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_data_unit_if;
    logic        ld_start;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_addr;
    logic [4:0]  ld_rd;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        ld_done;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd_out;
    logic [1:0]  ld_err;

    // Pipeline / memory side driving the unit
    modport master (
        output ld_start, ld_funct3, ld_addr, ld_rd, mem_gnt, mem_rvalid, mem_rdata,
        input  mem_req, mem_addr, busy, ld_done, ld_data, ld_rd_out, ld_err
    );

    // The load data unit itself
    modport slave (
        input  ld_start, ld_funct3, ld_addr, ld_rd, mem_gnt, mem_rvalid, mem_rdata,
        output mem_req, mem_addr, busy, ld_done, ld_data, ld_rd_out, ld_err
    );
endinterface

`default_nettype wire

// File: rtl/load_data_unit.sv
// ============================================================================
// Module      : load_data_unit
// Description : Issues one word-aligned read per load, then extracts and
//               sign/zero-extends the addressed lane for writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_data_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic           clk,
    input  wire logic           rst,
    load_data_unit_if.slave     bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam int                 c_cnt_w = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_err_ok    = 2'b00;
    localparam logic [1:0] c_err_align = 2'b01;
    localparam logic [1:0] c_err_f3    = 2'b10;
    localparam logic [1:0] c_err_tmo   = 2'b11;

    logic [1:0]         r_state;
    logic [2:0]         r_funct3;
    logic [1:0]         r_off;
    logic [4:0]         r_rd;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_req;
    logic [31:0]        r_mem_addr;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_data;
    logic [4:0]         r_rd_out;
    logic [1:0]         r_err;

    logic               w_illegal;
    logic               w_misal;
    logic [31:0]        w_shift;
    logic [31:0]        w_ext;
    logic [c_cnt_w-1:0] w_cnt_next;

    assign w_illegal = (bus.ld_funct3 == 3'b011) || (bus.ld_funct3[2:1] == 2'b11);
    assign w_misal   = ((bus.ld_funct3[1:0] == 2'b01) && bus.ld_addr[0]) ||
                       ((bus.ld_funct3[1:0] == 2'b10) && (bus.ld_addr[1:0] != 2'b00));

    // Saturating so a very long wait can never wrap back below the limit
    assign w_cnt_next = (r_cnt == {c_cnt_w{1'b1}}) ? r_cnt : r_cnt + c_cnt_w'(1);

    // Alignment was already enforced, so a byte shift by the offset covers every width
    always_comb begin
        w_shift = bus.mem_rdata >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_ext = {24'h0, w_shift[7:0]};
            3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_ext = {16'h0, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_funct3   <= 3'b000;
            r_off      <= 2'b00;
            r_rd       <= 5'd0;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_mem_addr <= 32'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= 32'h0;
            r_rd_out   <= 5'd0;
            r_err      <= c_err_ok;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.ld_start) begin
                        r_funct3 <= bus.ld_funct3;
                        r_off    <= bus.ld_addr[1:0];
                        r_rd     <= bus.ld_rd;
                        r_busy   <= 1'b1;
                        if (w_illegal || w_misal) begin
                            r_state  <= c_st_done;
                            r_done   <= 1'b1;
                            r_err    <= w_illegal ? c_err_f3 : c_err_align;
                            r_data   <= 32'h0;
                            r_rd_out <= bus.ld_rd;
                        end else begin
                            r_state    <= c_st_req;
                            r_req      <= 1'b1;
                            r_mem_addr <= {bus.ld_addr[31:2], 2'b00};
                        end
                    end
                end
                c_st_req: begin
                    if (bus.mem_gnt) begin
                        r_state <= c_st_wait;
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                c_st_wait: begin
                    if (bus.mem_rvalid) begin
                        r_state  <= c_st_done;
                        r_done   <= 1'b1;
                        r_data   <= w_ext;
                        r_err    <= c_err_ok;
                        r_rd_out <= r_rd;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next >= c_limit) begin
                            r_state  <= c_st_done;
                            r_done   <= 1'b1;
                            r_data   <= 32'h0;
                            r_err    <= c_err_tmo;
                            r_rd_out <= r_rd;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_req;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.busy      = r_busy;
    assign bus.ld_done   = r_done;
    assign bus.ld_data   = r_data;
    assign bus.ld_rd_out = r_rd_out;
    assign bus.ld_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_load_data_unit.sv
// ============================================================================
// Module      : tb_load_data_unit
// Description : Directed and randomized loads against a lane-extraction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_data_unit;

    localparam int c_timeout = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    load_data_unit_if bus ();

    load_data_unit #(.TIMEOUT_CYCLES(c_timeout)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Returns {err, data} from the load semantics: access size, signedness, alignment
    function automatic logic [33:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int          size;
        bit          sgn;
        logic [31:0] mask;
        logic [31:0] v;
        case (f3)
            3'b000:  begin size = 1; sgn = 1'b1; end
            3'b001:  begin size = 2; sgn = 1'b1; end
            3'b010:  begin size = 4; sgn = 1'b0; end
            3'b100:  begin size = 1; sgn = 1'b0; end
            3'b101:  begin size = 2; sgn = 1'b0; end
            default: begin size = 0; sgn = 1'b0; end
        endcase
        if (size == 0) return {2'b10, 32'h0};
        if ((int'(addr[1:0]) % size) != 0) return {2'b01, 32'h0};
        v    = rdata >> (8 * int'(addr[1:0]));
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        v    = v & mask;
        if (sgn && size < 4 && v[8*size-1]) v = v | ~mask;
        return {2'b00, v};
    endfunction

    // rv_dly < 0 means memory never answers
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
        logic [33:0] r;
        logic [1:0]  exp_err;
        logic [31:0] exp_data;
        r        = ref_load(f3, addr, rdata);
        exp_err  = r[33:32];
        exp_data = r[31:0];

        bus.ld_start  = 1'b1;
        bus.ld_funct3 = f3;
        bus.ld_addr   = addr;
        bus.ld_rd     = rd;
        tick();
        bus.ld_start  = 1'b0;
        bus.ld_funct3 = 3'($urandom);
        bus.ld_addr   = $urandom;
        bus.ld_rd     = 5'($urandom);

        if (exp_err != 2'b00) begin
            check("err_done", 32'(bus.ld_done), 32'd1);
            check("err_busy", 32'(bus.busy), 32'd1);
            check("err_no_req", 32'(bus.mem_req), 32'd0);
            check("err_code", 32'(bus.ld_err), 32'(exp_err));
            check("err_data", bus.ld_data, 32'h0);
            check("err_rd", 32'(bus.ld_rd_out), 32'(rd));
            tick();
            check("err_idle", 32'({bus.busy, bus.ld_done, bus.mem_req}), 32'd0);
        end else begin
            check("req", 32'(bus.mem_req), 32'd1);
            check("req_addr", bus.mem_addr, {addr[31:2], 2'b00});
            check("req_busy", 32'(bus.busy), 32'd1);
            for (int i = 0; i < gnt_dly; i++) begin
                bus.ld_start   = 1'($urandom);
                bus.ld_funct3  = 3'($urandom);
                bus.ld_addr    = $urandom;
                bus.mem_rvalid = 1'($urandom);
                bus.mem_rdata  = $urandom;
                tick();
                check("req_hold", 32'(bus.mem_req), 32'd1);
                check("addr_hold", bus.mem_addr, {addr[31:2], 2'b00});
            end
            bus.ld_start   = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_gnt    = 1'b1;
            tick();
            bus.mem_gnt = 1'b0;
            check("req_drop", 32'(bus.mem_req), 32'd0);
            if (rv_dly < 0) begin
                for (int i = 1; i < c_timeout; i++) begin
                    check("tmo_wait", 32'(bus.ld_done), 32'd0);
                    tick();
                end
                check("tmo_done", 32'(bus.ld_done), 32'd1);
                check("tmo_err", 32'(bus.ld_err), 32'd3);
                check("tmo_data", bus.ld_data, 32'h0);
                check("tmo_rd", 32'(bus.ld_rd_out), 32'(rd));
                exp_data = 32'h0;
            end else begin
                for (int i = 0; i < rv_dly; i++) begin
                    check("wait_nodone", 32'(bus.ld_done), 32'd0);
                    bus.mem_rdata = $urandom;
                    tick();
                end
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rdata;
                tick();
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = $urandom;
                check("done", 32'(bus.ld_done), 32'd1);
                check("data", bus.ld_data, exp_data);
                check("err_ok", 32'(bus.ld_err), 32'd0);
                check("rd_out", 32'(bus.ld_rd_out), 32'(rd));
            end
            tick();
            check("done_pulse", 32'({bus.ld_done, bus.busy}), 32'd0);
            check("data_hold", bus.ld_data, exp_data);
        end
    endtask

    initial begin
        bus.ld_start   = 1'b0;
        bus.ld_funct3  = 3'b000;
        bus.ld_addr    = 32'h0;
        bus.ld_rd      = 5'd0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_outs", 32'({bus.busy, bus.ld_done, bus.ld_err, bus.ld_rd_out}), 32'd0);
        check("rst_data", bus.ld_data, 32'h0);
        rst = 1'b0;
        tick();

        do_load(3'b000, 32'h0000_0103, 5'd7,  32'h80FF_1234, 0, 0);
        do_load(3'b101, 32'h0000_0102, 5'd9,  32'h8001_7FFF, 0, 1);
        do_load(3'b001, 32'h0000_0102, 5'd10, 32'h8001_7FFF, 1, 0);
        do_load(3'b010, 32'h0000_0101, 5'd11, 32'h1234_5678, 0, 0);
        do_load(3'b011, 32'h0000_0100, 5'd12, 32'h1234_5678, 0, 0);
        do_load(3'b010, 32'h0000_0200, 5'd13, 32'hDEAD_BEEF, 5, 0);
        do_load(3'b100, 32'h0000_0301, 5'd14, 32'h0000_8000, 0, -1);

        // Reset while waiting, then a stale response that must be ignored
        bus.ld_start  = 1'b1;
        bus.ld_funct3 = 3'b010;
        bus.ld_addr   = 32'h0000_0400;
        bus.ld_rd     = 5'd3;
        tick();
        bus.ld_start = 1'b0;
        bus.mem_gnt  = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        tick();
        bus.mem_rvalid = 1'b0;
        check("stale_done", 32'(bus.ld_done), 32'd0);
        check("stale_outs", 32'({bus.busy, bus.mem_req, bus.ld_err, bus.ld_rd_out}), 32'd0);
        check("stale_data", bus.ld_data, 32'h0);
        check("stale_addr", bus.mem_addr, 32'h0);
        tick();
        check("stale_done2", 32'(bus.ld_done), 32'd0);

        for (int n = 0; n < 40; n++) begin
            int rv;
            rv = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, c_timeout - 2));
            do_load(3'($urandom), $urandom, 5'($urandom), $urandom,
                    int'($urandom_range(0, 4)), rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
